// File: rtl/sklansky_wb_seq.sv
// Wishbone sequencer driving one external 16-bit Sklansky adder limb by limb.
// Define SKLANSKY_SUB_EN to enable subtraction (CTRL.b3 SUB).
module sklansky_wb_seq #(
    parameter int          WORDS     = 2,
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    input  logic [15:0] add_sum,
    input  logic        add_cout,
    output logic        irq_o
);

    localparam logic [31:0] MASK =
        (WORDS >= 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LIMB,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        idx;
    logic        last_limb;
    logic        busy;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;
    logic        cin_q;
    logic        irq_en_q;
    logic        done_q;
    logic        cout_q;
    logic        carry_q;
    logic        sub_q;

    logic        hit;
    logic        valid;
    logic        wr;
    logic [2:0]  reg_idx;
    logic        wr_ctrl;
    logic        wr_a;
    logic        wr_b;
    logic        start_go;
    logic [31:0] rdata;
    logic        unused;

    assign unused    = ^wbs_adr_i[1:0];
    assign hit       = (wbs_adr_i[31:5] == ADDR_BASE[31:5]);
    assign valid     = wbs_cyc_i & wbs_stb_i & hit;
    // Writes commit on the edge that closes the ack cycle.
    assign wr        = valid & wbs_ack_o & wbs_we_i;
    assign reg_idx   = wbs_adr_i[4:2];
    assign wr_ctrl   = wr & (reg_idx == 3'd0);
    assign wr_a      = wr & (reg_idx == 3'd1);
    assign wr_b      = wr & (reg_idx == 3'd2);
    assign busy      = (state == S_LIMB);
    assign last_limb = (int'(idx) == WORDS - 1);
    assign start_go  = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[0] & ~busy;
    assign irq_o     = done_q & irq_en_q;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] nw,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // Bus handshake: single-cycle ack, read data only during ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= valid & ~wbs_ack_o;
            wbs_dat_o <= (valid & ~wbs_ack_o) ? rdata : '0;
        end
    end

    // Register read mux.
    always_comb begin
        rdata = '0;
        case (reg_idx)
            3'd0: rdata = {21'b0, cout_q, done_q, busy, 4'b0,
                           sub_q, irq_en_q, cin_q, 1'b0};
            3'd1: rdata = op_a;
            3'd2: rdata = op_b;
            3'd3: rdata = result;
            default: rdata = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = start_go ? S_LIMB : S_IDLE;
            S_LIMB:  state_nxt = last_limb ? S_DONE : S_LIMB;
            S_DONE:  state_nxt = start_go ? S_LIMB : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Adder drive: current limb while sequencing, zero otherwise.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == S_LIMB) begin
            add_a = op_a[{idx, 4'b0} +: 16];
            add_b = sub_q ? ~op_b[{idx, 4'b0} +: 16]
                          : op_b[{idx, 4'b0} +: 16];
            if (idx == 1'b0) add_cin = sub_q | cin_q;
            else             add_cin = carry_q;
        end
    end

    // Operands, control bits, limb counter and result capture.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            op_a     <= '0;
            op_b     <= '0;
            result   <= '0;
            cin_q    <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            carry_q  <= 1'b0;
            idx      <= 1'b0;
        end else begin
            if (wr_a & ~busy) op_a <= merge(op_a, wbs_dat_i, wbs_sel_i) & MASK;
            if (wr_b & ~busy) op_b <= merge(op_b, wbs_dat_i, wbs_sel_i) & MASK;
            if (wr_ctrl & wbs_sel_i[0]) begin
                irq_en_q <= wbs_dat_i[2];
                if (~busy) cin_q <= wbs_dat_i[1];
            end
            // Completion set beats a same-cycle clear.
            if (busy & last_limb)
                done_q <= 1'b1;
            else if (start_go)
                done_q <= 1'b0;
            else if (wr_ctrl & wbs_sel_i[1] & wbs_dat_i[9])
                done_q <= 1'b0;
            if (busy) begin
                result[{idx, 4'b0} +: 16] <= add_sum;
                carry_q <= add_cout;
                if (last_limb) cout_q <= add_cout;
            end
            if (start_go)
                idx <= 1'b0;
            else if (busy & ~last_limb)
                idx <= idx + 1'b1;
        end
    end

`ifdef SKLANSKY_SUB_EN
    // Subtract mode bit, frozen while an operation runs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            sub_q <= 1'b0;
        else if (wr_ctrl & wbs_sel_i[0] & ~busy)
            sub_q <= wbs_dat_i[3];
    end
`else
    assign sub_q = 1'b0;
`endif

endmodule
